dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two, >=4).
REQ-002 Parameter WAIT_CYCLES, default 2, extra cycles between request acceptance and response (0..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  MA stage presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_ld  input  1  request is a load.
REQ-008 req_st  input  1  request is a store.
REQ-009 req_addr  input  32  byte address (mar).
REQ-010 req_wdata  input  32  store data (mdr).
REQ-011 rsp_valid  output  1  one-cycle pulse marking a completed request.
REQ-012 rsp_data  output  32  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  request completed without memory access.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 States IDLE, WAIT, RESP; req_ready = (state==IDLE), combinational from state only.
REQ-016 Accept = req_valid & req_ready at a rising edge; req_ld, req_st, req_addr, req_wdata captured into internal registers at accept.
REQ-017 IDLE->WAIT on accept when WAIT_CYCLES>0; IDLE->RESP on accept when WAIT_CYCLES==0; otherwise stay IDLE.
REQ-018 WAIT: down-counter loaded with WAIT_CYCLES-1 at accept; WAIT->RESP at the edge where counter==0.
REQ-019 RESP lasts exactly one cycle; rsp_valid=1 only in RESP; RESP->IDLE unconditionally.
REQ-020 Latency: accept at edge T -> rsp_valid high in the cycle after edge T+WAIT_CYCLES; next accept earliest at edge T+WAIT_CYCLES+2.
REQ-021 Word index = captured addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (addresses alias modulo DEPTH_WORDS*4).
REQ-022 Store: memory word written on the edge entering RESP; rsp_data=0, rsp_err=0.
REQ-023 Load: memory word read on the edge entering RESP and held on rsp_data during RESP; rsp_err=0.
REQ-024 req_ld==req_st (both or neither) on accept: request consumed, no memory read or write, RESP with rsp_err=1, rsp_data=0.
REQ-025 Outside RESP, rsp_data=0 and rsp_err=0.
REQ-026 Inputs ignored while req_ready=0; no queuing of requests.

Reset
REQ-027 rst_n low: state=IDLE, counter=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, captured request registers cleared; req_ready=1 once state is IDLE.
REQ-028 Reset during WAIT or RESP aborts the request: a pending store is not written, no response is issued.
REQ-029 Memory array contents are not initialised or cleared by reset.

Configuration
REQ-030 Macro DMEM_ALIGN_CHECK_EN defined: accepted request with addr[1:0]!=0 performs no access and responds rsp_err=1, rsp_data=0, same latency.
REQ-031 Macro DMEM_ALIGN_CHECK_EN undefined: addr[1:0] ignored; misaligned requests access the containing word normally.

Structure
REQ-032 Shared package dmem_pkg holds the state encoding (IDLE/WAIT/RESP), WORD_W=32 and the counter width constant.
REQ-033 Sub-module dmem_array: DEPTH_WORDS x 32 storage with synchronous write-enable and synchronous read; FSM, counter and capture registers in dmem_responder.

Verification
REQ-034 WAIT_CYCLES=2; store 0xDEADBEEF to 0x10 accepted at edge 5 -> rsp_valid in cycle after edge 7, rsp_err=0, rsp_data=0, req_ready low until after RESP.
REQ-035 Following load from 0x10 -> rsp_data=0xDEADBEEF, rsp_err=0, rsp_valid high for exactly one cycle.
REQ-036 DEPTH_WORDS=1024; store 0x12345678 to 0x1010, then load 0x10 -> rsp_data=0x12345678 (aliasing).
REQ-037 req_ld=req_st=1 on accept -> rsp_err=1, rsp_data=0; subsequent load of previously stored word unchanged.
REQ-038 rst_n pulsed low during WAIT of store 0xCAFEF00D to 0x20 -> no rsp_valid, busy=0, req_ready=1; later load of 0x20 returns prior contents.
REQ-039 DMEM_ALIGN_CHECK_EN defined, store to 0x12 -> rsp_err=1, word at 0x10 unchanged; undefined -> word at 0x10 written.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants for the data-memory responder: FSM state
//                encoding, data word width and wait-counter width, plus a
//                helper computing the wait-counter reload value.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;
    localparam int ST_W   = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
    localparam logic [ST_W-1:0] ST_RESP = 2'd2;

    // Counter reload: WAIT spans waitCycles edges, the last one at count zero
    function automatic logic [CNT_W-1:0] cnt_init(input int waitCycles);
        return (waitCycles > 0) ? CNT_W'(waitCycles - 1) : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : DEPTH_WORDS x 32-bit storage, synchronous write enable and
//                synchronous (registered) read. Contents are never reset.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           wrEn,
    input  logic                           rdEn,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [WORD_W-1:0]              wrData,
    output logic [WORD_W-1:0]              rdData
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_rdData;

    // Single-port storage: write and registered read share one address
    always_ff @(posedge clk) begin
        if (wrEn) begin
            r_mem[addr] <= wrData;
        end
        if (rdEn) begin
            r_rdData <= r_mem[addr];
        end
    end

    assign rdData = r_rdData;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Fixed-latency data-memory responder for the MA stage.
//                IDLE accepts one request, WAIT burns WAIT_CYCLES edges,
//                RESP pulses rsp_valid for one cycle with load data or error.
//                Optional macro DMEM_ALIGN_CHECK_EN turns misaligned
//                accesses into error responses with no memory access.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_ld,
    input  logic              req_st,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam int               c_AW       = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] c_CNT_INIT = cnt_init(WAIT_CYCLES);
    localparam bit               c_NO_WAIT  = (WAIT_CYCLES == 0);

    logic [ST_W-1:0]   r_state;
    logic [ST_W-1:0]   w_nextState;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ld;
    logic              r_st;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;

    logic              w_accept;
    logic              w_enterResp;
    logic              w_fromInputs;
    logic              w_selLd;
    logic              w_selSt;
    logic              w_selMis;
    logic [c_AW-1:0]   w_selIdx;
    logic [WORD_W-1:0] w_selWdata;
    logic              w_memWr;
    logic              w_memRd;
    logic [WORD_W-1:0] w_rdData;
    logic              w_rspMis;
    logic              w_rspErr;
    logic              w_rspLoad;
    logic              w_unused;

    assign w_accept = req_valid & req_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nextState = c_NO_WAIT ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_nextState = ST_RESP;
                end
            end
            ST_RESP: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Output decode: everything is a function of the current state
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = w_rspErr;
                rsp_data  = w_rspLoad ? w_rdData : '0;
            end
            default: ;
        endcase
    end

    // Request capture and wait countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_ld    <= 1'b0;
            r_st    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= c_CNT_INIT;
            r_ld    <= req_ld;
            r_st    <= req_st;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // With no wait the access happens on the accept edge itself, before the
    // capture registers are loaded, so the request is taken from the inputs.
    assign w_fromInputs = (r_state == ST_IDLE);
    assign w_selLd      = w_fromInputs ? req_ld : r_ld;
    assign w_selSt      = w_fromInputs ? req_st : r_st;
    assign w_selIdx     = w_fromInputs ? req_addr[c_AW+1:2] : r_addr[c_AW+1:2];
    assign w_selWdata   = w_fromInputs ? req_wdata : r_wdata;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_selMis = w_fromInputs ? (req_addr[1:0] != 2'b00) : (r_addr[1:0] != 2'b00);
    assign w_rspMis = (r_addr[1:0] != 2'b00);
`else
    assign w_selMis = 1'b0;
    assign w_rspMis = 1'b0;
`endif

    assign w_enterResp = (r_state != ST_RESP) && (w_nextState == ST_RESP);
    assign w_memWr     = w_enterResp & w_selSt & ~w_selLd & ~w_selMis;
    assign w_memRd     = w_enterResp & w_selLd & ~w_selSt & ~w_selMis;

    assign w_rspErr  = (r_ld == r_st) | w_rspMis;
    assign w_rspLoad = r_ld & ~r_st & ~w_rspMis;

    // Address bits outside the word index alias and are intentionally dropped
    assign w_unused = &{1'b0, r_addr[WORD_W-1:c_AW+2], r_addr[1:0]};

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk    (clk),
        .wrEn   (w_memWr),
        .rdEn   (w_memRd),
        .addr   (w_selIdx),
        .wrData (w_selWdata),
        .rdData (w_rdData)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder: directed scenarios
//                followed by random traffic against a word-array model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WAITC = 2;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ld    = 1'b0;
    logic        req_st    = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [DEPTH];
    bit          known [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ld    (req_ld),
        .req_st    (req_st),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete transaction, checked against the word-array model
    task automatic do_req(input logic ld, input logic st, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit jam);
        int          idx;
        int          k;
        bit          seen;
        bit          expErr;
        bit          chkData;
        logic [31:0] expData;

        idx    = int'((addr / 4) % DEPTH);
        expErr = (ld == st);
`ifdef DMEM_ALIGN_CHECK_EN
        if ((addr % 4) != 0) expErr = 1'b1;
`endif
        expData = '0;
        chkData = 1'b1;
        if (!expErr && ld) begin
            if (known[idx]) expData = model[idx];
            else            chkData = 1'b0;
        end

        @(negedge clk);
        chk("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1;
        req_ld    = ld;
        req_st    = st;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        if (!expErr && st && !ld) begin
            model[idx] = wdata;
            known[idx] = 1'b1;
        end
        if (jam) begin
            req_ld    = 1'($urandom);
            req_st    = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
        end else begin
            req_valid = 1'b0;
        end

        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                chk("wait_ready_low", req_ready, 1'b0);
                chk("wait_busy_high", busy, 1'b1);
                @(posedge clk);
                #1;
                k++;
            end
        end
        req_valid = 1'b0;
        if (!seen) begin
            chk("rsp_timeout", 32'(seen), 32'd1);
            return;
        end
        chk("latency", k, WAITC);
        chk("rsp_err", rsp_err, expErr);
        if (chkData) chk("rsp_data", rsp_data, expData);
        chk("resp_ready_low", req_ready, 1'b0);
        chk("resp_busy_high", busy, 1'b1);

        @(posedge clk);
        #1;
        chk("rsp_one_cycle", rsp_valid, 1'b0);
        chk("idle_ready", req_ready, 1'b1);
        chk("idle_data_zero", rsp_data, 32'h0);
        chk("idle_err_zero", rsp_err, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r;
        logic        ld;
        logic        st;
        logic [31:0] addr;

        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_data", rsp_data, 32'h0);
        chk("rst_err", rsp_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Store then load back
        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        // Aliasing: 0x1010 maps onto the same word as 0x10
        do_req(1'b0, 1'b1, 32'h1010, 32'h12345678, 1'b0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        // Both / neither flags: error, memory untouched
        do_req(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 1'b0);
        do_req(1'b0, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        // Reset during WAIT aborts a pending store
        do_req(1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_ld    = 1'b0;
        req_st    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rstw_busy_before", busy, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_ready", req_ready, 1'b1);
        chk("rstw_valid", rsp_valid, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rstw_no_rsp", rsp_valid, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rstw_no_rsp_after", rsp_valid, 1'b0);
        end
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        // Misaligned store: error with alignment checking, normal write otherwise
        do_req(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, 1'b0);
        do_req(1'b0, 1'b1, 32'h12, 32'h0BADF00D, 1'b0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);

        // Random traffic with junk driven while busy
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 7);
            if (r < 3) begin
                ld = 1'b1; st = 1'b0;
            end else if (r < 6) begin
                ld = 1'b0; st = 1'b1;
            end else if (r == 6) begin
                ld = 1'b1; st = 1'b1;
            end else begin
                ld = 1'b0; st = 1'b0;
            end
            addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            do_req(ld, st, addr, $urandom, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
